cpu_busctl: RTL and testbench
=============================

# cpu_busctl

Bus controller that sits beside the Z80 core in the CPU wrapper and drives the core's wait and interrupt inputs. It inserts a parametrised number of wait states into memory and I/O cycles and collects up to eight edge-triggered interrupt sources. During interrupt acknowledge it supplies an IM2 vector for the highest-priority source. It replaces the tied-off `WAIT_n`/`INT_n` of the current wrapper; the wrapper muxes `vec` onto the core's data input while `vec_oe` is high.

## Interface
- `NIRQ`, default 4: number of interrupt sources, range 1..8.
- `MEMWAIT`, default 0: extra wait states per memory cycle, range 0..15.
- `IOWAIT`, default 1: extra wait states per I/O cycle, on top of the core's automatic one; range 0..15.
- `VECBASE`, default 8'hE0: IM2 vector base.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `cep` in 1: core positive clock enable; all bus sampling and wait counting happen on `cep` ticks.
- `mreq`, `iorq`, `rd`, `wr`, `m1` in 1 each: active-low core strobes.
- `irq` in NIRQ: interrupt requests, active-high, rising-edge sensitive, synchronous to `clock`.
- `mask` in NIRQ: per-source enable, 1 = enabled.
- `wait_n` out 1: to core `WAIT_n`.
- `int_n` out 1: to core `INT_n`.
- `vec` out 8: IM2 vector.
- `vec_oe` out 1: vector valid and driven.
- `pending` out NIRQ: latched request bits (status read-back).

## Operation
- Cycle start is detected on a `cep` tick where (`mreq` low or `iorq` low) and both were high at the previous `cep` tick. Cycle kind:
  - memory: `mreq` low.
  - I/O: `iorq` low and `m1` high.
  - acknowledge: `iorq` low and `m1` low.
- Wait FSM states:
  - IDLE: on a memory start, load count = MEMWAIT; on an I/O start, load count = IOWAIT. Nonzero count goes to WAIT; zero count goes to HOLD. An acknowledge start goes to HOLD with no waits.
  - WAIT: `wait_n` low; decrement on each `cep`; go to HOLD on the tick the count reaches 0.
  - HOLD: `wait_n` high; return to IDLE on the first `cep` with `mreq` and `iorq` both high.
  - Refresh cycles (`mreq` low, `rd`/`wr` high, `m1` high) never wait: memory cycles with `rd` and `wr` both high at start take count 0.
- Counter width is 4 bits.
- Interrupt latch:
  - A rising edge on `irq[i]` (registered previous value) sets `pending[i]` regardless of `mask`.
  - `int_n` is registered and equals ~|(`pending` & `mask`).
- Acknowledge handling:
  - At the acknowledge start, select the lowest index i with `pending[i]` & `mask[i]`.
  - Set `vec` = VECBASE + {i,1'b0} (8-bit wrap), assert `vec_oe`, and clear `pending[i]`.
  - `vec_oe` drops when `iorq` returns high.
  - If nothing is eligible at acknowledge (masked after `int_n` fell), `vec` = VECBASE + {NIRQ,1'b0} as the spurious vector, and no bit is cleared.
- Same-clock edge on `irq[i]` and acknowledge-clear of bit i: the set wins and `pending[i]` stays 1.
- Mask changes take effect on `int_n` one clock later.

## Timing
- Reset values: `wait_n`=1, `int_n`=1, `vec`=8'h00, `vec_oe`=0, `pending`=0, FSM=IDLE, count=0, edge registers=0.
- Reset asserted mid-cycle: all of the above apply immediately (asynchronously). After release, the FSM starts in IDLE and the first start is detected against "previous = both high".
- `wait_n` falls the clock after the start-detect `cep` tick and stays low for exactly N `cep` ticks (N = MEMWAIT or IOWAIT).
- Interrupt latency, `irq` edge to `int_n` low: 2 clocks (edge register, then pending, then `int_n` register, counted from the `irq` sample).
- `vec_oe` rises the clock after the acknowledge start tick; `vec` is stable before `vec_oe` rises.

## Structure
- Package `cpu_pkg`:
  - FSM state enum (IDLE, WAIT, HOLD).
  - Cycle-kind constants.
  - Function `vec_of(base, index)`.
  - Parameter range checks (via a generate-time `$error`).
- One sub-module, `irq_prio`: an NIRQ-input lowest-index-first priority encoder with outputs `valid` and `index[2:0]`.
- Everything else lives inline in `cpu_busctl`.

## Test plan
- MEMWAIT=2: memory read start -> `wait_n` low for exactly 2 `cep` ticks, then high until `mreq` high; FSM back in IDLE.
- IOWAIT=1, MEMWAIT=0: I/O write -> 1 wait tick. A following opcode fetch -> `wait_n` stays 1. A refresh cycle -> `wait_n` stays 1.
- NIRQ=4, `mask`=4'b1111: pulse `irq[2]` and `irq[1]` together -> `int_n` low.
  - First acknowledge -> `vec`=8'hE2 and `pending`=4'b0100.
  - Second acknowledge -> `vec`=8'hE4 and `pending`=0; then `int_n` high.
- `irq[0]` edge on the same clock as the acknowledge that clears bit 0 -> `pending[0]` stays 1 and `int_n` stays low.
- Set `pending[3]`, clear `mask[3]` after `int_n` falls, then acknowledge -> `vec`=8'hE8 (spurious) and `pending[3]` stays 1.
- Assert `reset` during WAIT with count 3 -> `wait_n`=1 immediately. After release, the next memory start yields a full MEMWAIT wait.

Source files
------------

// File: rtl/cpu_busctl_pkg.sv
// Shared types, constants and helpers for the Z80 bus controller.
package cpu_pkg;

   localparam int CNT_W    = 4;
   localparam int MAX_NIRQ = 8;
   localparam int MAX_WAIT = 15;

   // Wait-state sequencer states.
   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD
   } state_t;

   // Kind of bus cycle seen at a cycle start.
   typedef enum logic [1:0] {
      CYC_NONE,
      CYC_MEM,
      CYC_IO,
      CYC_ACK
   } cycle_t;

   // Classify the active-low strobes; memory takes precedence over I/O.
   function automatic cycle_t cycle_kind(input logic mreq, input logic iorq, input logic m1);
      if (!mreq)      return CYC_MEM;
      else if (!iorq) return m1 ? CYC_IO : CYC_ACK;
      else            return CYC_NONE;
   endfunction

   // IM2 vector: base plus twice the source index, wrapping at 8 bits.
   function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [3:0] index);
      return base + {3'b000, index, 1'b0};
   endfunction

   // Legal parameter ranges for cpu_busctl.
   function automatic bit params_ok(input int nirq, input int memwait, input int iowait);
      return (nirq >= 1) && (nirq <= MAX_NIRQ) &&
             (memwait >= 0) && (memwait <= MAX_WAIT) &&
             (iowait >= 0) && (iowait <= MAX_WAIT);
   endfunction

endpackage

// File: rtl/cpu_busctl_irq_prio.sv
// Lowest-index-first priority encoder for the interrupt sources.
module irq_prio #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [2:0]   index
);

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      valid = 1'b0;
      index = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/cpu_busctl.sv
// Z80 bus controller: wait-state insertion, edge-triggered interrupt latch
// and IM2 vector supply during interrupt acknowledge.
module cpu_busctl
   import cpu_pkg::*;
#(
   parameter int         NIRQ    = 4,
   parameter int         MEMWAIT = 0,
   parameter int         IOWAIT  = 1,
   parameter logic [7:0] VECBASE = 8'hE0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            cep,
   input  logic            mreq,
   input  logic            iorq,
   input  logic            rd,
   input  logic            wr,
   input  logic            m1,
   input  logic [NIRQ-1:0] irq,
   input  logic [NIRQ-1:0] mask,
   output logic            wait_n,
   output logic            int_n,
   output logic [7:0]      vec,
   output logic            vec_oe,
   output logic [NIRQ-1:0] pending
);

   if (!params_ok(NIRQ, MEMWAIT, IOWAIT)) begin : g_param_err
      $error("cpu_busctl: NIRQ must be 1..8, MEMWAIT and IOWAIT 0..15");
   end

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count, count_nxt, load_cnt;
   logic               prev_idle;
   logic               bus_idle, start, ack_start;
   cycle_t             kind;
   logic [NIRQ-1:0]    irq_s, irq_p, rise, eligible, ack_clr;
   logic               prio_valid;
   logic [2:0]         prio_index;

   assign bus_idle  = mreq & iorq;
   assign kind      = cycle_kind(mreq, iorq, m1);
   assign start     = cep & ~bus_idle & prev_idle;
   assign ack_start = start && (state == IDLE) && (kind == CYC_ACK);
   assign wait_n    = (state != WAIT);

   // Wait count loaded at a cycle start; refresh (rd and wr high) never waits.
   always_comb begin
      unique case (kind)
         CYC_MEM: load_cnt = (rd && wr) ? '0 : CNT_W'(MEMWAIT);
         CYC_IO:  load_cnt = CNT_W'(IOWAIT);
         default: load_cnt = '0;
      endcase
   end

   // Next-state logic for the wait sequencer.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      state_nxt = state;
      count_nxt = count;
      unique case (state)
         IDLE: begin
            if (start) begin
               count_nxt = load_cnt;
               state_nxt = (load_cnt != '0) ? WAIT : HOLD;
            end
         end
         WAIT: begin
            if (cep) begin
               count_nxt = count - CNT_W'(1);
               if (count == CNT_W'(1)) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (cep && bus_idle) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sequencer state and counter registers.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Strobe history for start detection; after reset the bus counts as idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)   prev_idle <= 1'b1;
      else if (cep) prev_idle <= bus_idle;
   end

   // Interrupt sample and previous-value registers for edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_s <= '0;
         irq_p <= '0;
      end else begin
         irq_s <= irq;
         irq_p <= irq_s;
      end
   end

   assign rise     = irq_s & ~irq_p;
   assign eligible = pending & mask;

   irq_prio #(.N(NIRQ)) u_prio (
      .req   (eligible),
      .valid (prio_valid),
      .index (prio_index)
   );

   // One-hot clear of the source being acknowledged.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NIRQ; i++) begin
         ack_clr[i] = ack_start && prio_valid && (prio_index == 3'(i));
      end
   end

   // Pending latch and INT_n; a new edge beats a simultaneous acknowledge clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending <= '0;
         int_n   <= 1'b1;
      end else begin
         pending <= (pending & ~ack_clr) | rise;
         int_n   <= ~|eligible;
      end
   end

   // Vector capture at acknowledge start; output enable ends with IORQ high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vec    <= 8'h00;
         vec_oe <= 1'b0;
      end else if (ack_start) begin
         vec    <= prio_valid ? vec_of(VECBASE, {1'b0, prio_index})
                              : vec_of(VECBASE, 4'(NIRQ));
         vec_oe <= 1'b1;
      end else if (cep && iorq) begin
         vec_oe <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_busctl.sv
// Self-checking bench for cpu_busctl: three instances with different
// memory wait counts share one stimulus and are compared every clock
// against a behavioural model, plus directed literal checks.
module tb_cpu_busctl;

   localparam int         NI = 4;
   localparam int         ND = 3;
   localparam int         MW [ND] = '{2, 0, 5};
   localparam int         IW = 1;
   localparam logic [7:0] VB = 8'hE0;

   logic clk = 1'b0, rst_n = 1'b1, cep = 1'b1;
   logic mreq = 1'b1, iorq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1;
   logic [NI-1:0] irq = '0, mask = '1;

   logic          wait_n_o [ND];
   logic          int_n_o  [ND];
   logic          vec_oe_o [ND];
   logic [7:0]    vec_o    [ND];
   logic [NI-1:0] pend_o   [ND];

   int n_tests = 0, n_fail = 0;
   bit slow = 1'b0;
   int lows [ND];
   logic [7:0]    cap_vec;
   logic          cap_oe;
   logic [NI-1:0] cap_pend;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      cpu_busctl #(.NIRQ(NI), .MEMWAIT(MW[g]), .IOWAIT(IW), .VECBASE(VB)) u_dut (
         .clock   (clk),
         .reset   (rst_n),
         .cep     (cep),
         .mreq    (mreq),
         .iorq    (iorq),
         .rd      (rd),
         .wr      (wr),
         .m1      (m1),
         .irq     (irq),
         .mask    (mask),
         .wait_n  (wait_n_o[g]),
         .int_n   (int_n_o[g]),
         .vec     (vec_o[g]),
         .vec_oe  (vec_oe_o[g]),
         .pending (pend_o[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_wl   [ND];   // wait ticks still owed in the current cycle
   bit            m_busy [ND];   // inside a bus cycle (start seen, not yet ended)
   bit            m_prev [ND];   // bus idle at previous cep tick
   logic [NI-1:0] m_pend [ND];
   bit            m_intn [ND];
   logic [7:0]    m_vec  [ND];
   bit            m_oe   [ND];
   logic [NI-1:0] m_irq_s, m_irq_p;

   task automatic model_reset();
      for (int k = 0; k < ND; k++) begin
         m_wl[k] = 0; m_busy[k] = 0; m_prev[k] = 1; m_pend[k] = '0;
         m_intn[k] = 1; m_vec[k] = 8'h00; m_oe[k] = 0;
      end
      m_irq_s = '0;
      m_irq_p = '0;
   endtask

   task automatic model_step();
      logic [NI-1:0] rise, elig, clr;
      bit bus_idle, found, intn_next;
      rise    = m_irq_s & ~m_irq_p;
      m_irq_p = m_irq_s;
      m_irq_s = irq;
      bus_idle = mreq && iorq;
      for (int k = 0; k < ND; k++) begin
         elig      = m_pend[k] & mask;
         intn_next = (elig == '0);
         clr       = '0;
         if (cep) begin
            if (!m_busy[k]) begin
               if (!bus_idle && m_prev[k]) begin
                  m_busy[k] = 1;
                  if (!mreq)    m_wl[k] = (rd && wr) ? 0 : MW[k];
                  else if (m1)  m_wl[k] = IW;
                  else begin
                     m_wl[k] = 0;
                     found = 0;
                     for (int i = 0; i < NI; i++) begin
                        if (!found && elig[i]) begin
                           found = 1;
                           clr[i] = 1'b1;
                           m_vec[k] = VB + 8'(2 * i);
                        end
                     end
                     if (!found) m_vec[k] = VB + 8'(2 * NI);
                     m_oe[k] = 1;
                  end
               end
            end else if (m_wl[k] > 0) begin
               m_wl[k]--;
            end else if (bus_idle) begin
               m_busy[k] = 0;
            end
            if (m_oe[k] && iorq) m_oe[k] = 0;
            m_prev[k] = bus_idle;
         end
         m_pend[k] = (m_pend[k] & ~clr) | rise;
         m_intn[k] = intn_next;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < ND; k++) begin
            check($sformatf("model wait_n[%0d]", k), 32'(wait_n_o[k]), 32'(m_wl[k] == 0));
            check($sformatf("model int_n[%0d]", k),  32'(int_n_o[k]),  32'(m_intn[k]));
            check($sformatf("model vec_oe[%0d]", k), 32'(vec_oe_o[k]), 32'(m_oe[k]));
            check($sformatf("model vec[%0d]", k),    32'(vec_o[k]),    32'(m_vec[k]));
            check($sformatf("model pending[%0d]", k), 32'(pend_o[k]),  32'(m_pend[k]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      cep = 1'b1;
      @(negedge clk);
      if (slow) begin
         cep = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic set_bus(input logic mq, input logic io, input logic r, input logic w, input logic mo);
      mreq = mq; iorq = io; rd = r; wr = w; m1 = mo;
   endtask

   task automatic idle(input int n);
      set_bus(1, 1, 1, 1, 1);
      repeat (n) tick();
   endtask

   task automatic run_cycle(input logic mq, input logic io, input logic r, input logic w,
                            input logic mo, input int n);
      set_bus(mq, io, r, w, mo);
      for (int k = 0; k < ND; k++) lows[k] = 0;
      repeat (n) begin
         tick();
         for (int k = 0; k < ND; k++) if (!wait_n_o[k]) lows[k]++;
      end
      idle(2);
   endtask

   task automatic ack_cycle();
      set_bus(1, 0, 1, 1, 0);
      tick();
      cap_vec = vec_o[0]; cap_oe = vec_oe_o[0]; cap_pend = pend_o[0];
      tick();
      tick();
      idle(2);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         check("reset wait_n", 32'(wait_n_o[k]), 32'd1);
         check("reset int_n",  32'(int_n_o[k]),  32'd1);
         check("reset vec",    32'(vec_o[k]),    32'h00);
         check("reset vec_oe", 32'(vec_oe_o[k]), 32'd0);
         check("reset pending", 32'(pend_o[k]), 32'd0);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Memory read with cep at half rate.
      slow = 1'b1;
      idle(2);
      run_cycle(0, 1, 0, 1, 1, 8);
      check("memrd lows MEMWAIT=2", 32'(lows[0]), 32'd2);
      check("memrd lows MEMWAIT=0", 32'(lows[1]), 32'd0);
      check("memrd lows MEMWAIT=5", 32'(lows[2]), 32'd5);
      check("memrd end wait_n", 32'(wait_n_o[2]), 32'd1);
      slow = 1'b0;

      // I/O write, opcode fetch, refresh.
      run_cycle(1, 0, 1, 0, 1, 4);
      check("iowr lows", 32'(lows[1]), 32'd1);
      check("iowr lows A", 32'(lows[0]), 32'd1);
      run_cycle(0, 1, 0, 1, 0, 6);
      check("fetch lows MEMWAIT=0", 32'(lows[1]), 32'd0);
      check("fetch lows MEMWAIT=2", 32'(lows[0]), 32'd2);
      run_cycle(0, 1, 1, 1, 1, 3);
      check("refresh lows A", 32'(lows[0]), 32'd0);
      check("refresh lows C", 32'(lows[2]), 32'd0);

      // Two simultaneous requests, then two acknowledges.
      mask = 4'b1111;
      irq  = 4'b0110;
      @(negedge clk);
      irq = '0;
      @(negedge clk);
      check("irq pending latched", 32'(pend_o[0]), 32'b0110);
      check("irq int_n not yet",   32'(int_n_o[0]), 32'd1);
      @(negedge clk);
      check("irq int_n low", 32'(int_n_o[0]), 32'd0);
      ack_cycle();
      check("ack1 vec", 32'(cap_vec), 32'hE2);
      check("ack1 vec_oe", 32'(cap_oe), 32'd1);
      check("ack1 pending", 32'(cap_pend), 32'b0100);
      check("ack1 int_n", 32'(int_n_o[0]), 32'd0);
      ack_cycle();
      check("ack2 vec", 32'(cap_vec), 32'hE4);
      check("ack2 pending", 32'(cap_pend), 32'b0000);
      check("ack2 int_n high", 32'(int_n_o[0]), 32'd1);
      check("ack2 vec_oe dropped", 32'(vec_oe_o[0]), 32'd0);

      // New edge on bit 0 lands on the same clock as its acknowledge clear.
      irq = 4'b0001;
      @(negedge clk);
      irq = '0;
      repeat (3) @(negedge clk);
      check("irq0 pending", 32'(pend_o[0]), 32'b0001);
      irq = 4'b0001;
      @(negedge clk);
      set_bus(1, 0, 1, 1, 0);
      tick();
      cap_vec = vec_o[0];
      irq = '0;
      tick();
      tick();
      idle(2);
      check("race vec", 32'(cap_vec), 32'hE0);
      check("race pending kept", 32'(pend_o[0]), 32'b0001);
      check("race int_n low", 32'(int_n_o[0]), 32'd0);
      ack_cycle();
      check("race clear vec", 32'(cap_vec), 32'hE0);
      check("race clear pending", 32'(pend_o[0]), 32'b0000);

      // Spurious acknowledge after masking the only source.
      irq = 4'b1000;
      @(negedge clk);
      irq = '0;
      repeat (3) @(negedge clk);
      check("src3 int_n low", 32'(int_n_o[0]), 32'd0);
      mask = 4'b0111;
      repeat (2) @(negedge clk);
      check("masked int_n high", 32'(int_n_o[0]), 32'd1);
      ack_cycle();
      check("spurious vec", 32'(cap_vec), 32'hE8);
      check("spurious vec_oe", 32'(cap_oe), 32'd1);
      check("spurious pending", 32'(pend_o[0]), 32'b1000);
      mask = 4'b1111;
      repeat (2) @(negedge clk);
      check("unmasked int_n low", 32'(int_n_o[0]), 32'd0);

      // Reset in the middle of a long wait.
      set_bus(0, 1, 0, 1, 1);
      repeat (3) tick();
      check("pre-reset wait_n low", 32'(wait_n_o[2]), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < ND; k++) begin
         check("async reset wait_n", 32'(wait_n_o[k]), 32'd1);
         check("async reset int_n", 32'(int_n_o[k]), 32'd1);
         check("async reset pending", 32'(pend_o[k]), 32'd0);
         check("async reset vec_oe", 32'(vec_oe_o[k]), 32'd0);
         check("async reset vec", 32'(vec_o[k]), 32'h00);
      end
      set_bus(1, 1, 1, 1, 1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      run_cycle(0, 1, 0, 1, 1, 8);
      check("post-reset lows MEMWAIT=5", 32'(lows[2]), 32'd5);
      check("post-reset lows MEMWAIT=2", 32'(lows[0]), 32'd2);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
